// File: rtl/step_gen_pkg.sv
// rtl/step_gen_pkg.sv - shared FSM state type and sizing helpers for the step generator
package step_gen_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_RUN,
        ST_PULSE,
        ST_HOLD
    } axis_state_e;

    // Shortest spacing that still fits a full pulse plus the DIR hold window.
    function automatic int min_period(input int step_len, input int dir_hold);
        return step_len + dir_hold + 1;
    endfunction

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // The most-negative value is handled by the caller sign-extending first.
    function automatic logic [63:0] magnitude(input logic signed [63:0] v);
        return v[63] ? 64'(-v) : 64'(v);
    endfunction

endpackage

// File: rtl/step_axis_channel.sv
// rtl/step_axis_channel.sv - one STEP/DIR channel: FSM, period ticks, shared timer, position
module step_axis_channel
    import step_gen_pkg::*;
#(
    parameter int PERIOD_BITS = 32,
    parameter int POS_BITS    = 32,
    parameter int STEP_LEN    = 160,
    parameter int DIR_SETUP   = 40,
    parameter int DIR_HOLD    = 40
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          enable_i,
    input  logic signed [PERIOD_BITS-1:0] period_i,
    input  logic                          pos_load_i,
    input  logic        [POS_BITS-1:0]    pos_value_i,
    output logic        [POS_BITS-1:0]    position_o,
    output logic                          step_o,
    output logic                          dir_o,
    output logic                          busy_o
);

    localparam int TIMER_W = $clog2(max3(STEP_LEN, DIR_SETUP, DIR_HOLD) + 1);
    localparam logic [PERIOD_BITS-1:0] MIN_EFF    = PERIOD_BITS'(min_period(STEP_LEN, DIR_HOLD));
    localparam logic [TIMER_W-1:0]     SETUP_LOAD = TIMER_W'(DIR_SETUP - 1);
    localparam logic [TIMER_W-1:0]     PULSE_LOAD = TIMER_W'(STEP_LEN - 1);
    localparam logic [TIMER_W-1:0]     HOLD_LOAD  = TIMER_W'((DIR_HOLD > 0) ? DIR_HOLD - 1 : 0);

    axis_state_e                state_q;
    logic [PERIOD_BITS-1:0]     ticks_q;
    logic [TIMER_W-1:0]         timer_q;
    logic                       step_q;
    logic                       dir_q;
    logic [POS_BITS-1:0]        pos_q;

    logic [PERIOD_BITS-1:0]     mag;
    logic [PERIOD_BITS-1:0]     eff_period;
    logic                       go;
    logic                       fwd;
    logic                       hit;

    always_comb begin
        mag        = PERIOD_BITS'(magnitude(64'(period_i)));
        eff_period = (mag < MIN_EFF) ? MIN_EFF : mag;
        go         = enable_i && (mag != '0);
        fwd        = !period_i[PERIOD_BITS-1];
        hit        = (ticks_q + PERIOD_BITS'(1)) >= eff_period;
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
            ticks_q <= '0;
            timer_q <= '0;
            step_q  <= 1'b0;
            dir_q   <= 1'b1;
            pos_q   <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (go) begin
                        state_q <= ST_SETUP;
                        dir_q   <= fwd;
                        ticks_q <= '0;
                        timer_q <= SETUP_LOAD;
                    end
                end
                ST_SETUP: begin
                    if (timer_q == '0) state_q <= ST_RUN;
                    else               timer_q <= timer_q - 1'b1;
                end
                ST_RUN: begin
                    // A direction reversal goes back through IDLE so SETUP is honoured again.
                    if (!go || (fwd != dir_q)) begin
                        state_q <= ST_IDLE;
                    end else if (hit) begin
                        ticks_q <= '0;
                        step_q  <= 1'b1;
                        pos_q   <= dir_q ? pos_q + 1'b1 : pos_q - 1'b1;
                        timer_q <= PULSE_LOAD;
                        state_q <= ST_PULSE;
                    end else begin
                        ticks_q <= ticks_q + 1'b1;
                    end
                end
                ST_PULSE: begin
                    ticks_q <= ticks_q + 1'b1;
                    if (timer_q == '0) begin
                        step_q <= 1'b0;
                        if (DIR_HOLD == 0) begin
                            state_q <= ST_RUN;
                        end else begin
                            state_q <= ST_HOLD;
                            timer_q <= HOLD_LOAD;
                        end
                    end else begin
                        timer_q <= timer_q - 1'b1;
                    end
                end
                ST_HOLD: begin
                    ticks_q <= ticks_q + 1'b1;
                    if (timer_q == '0) state_q <= ST_RUN;
                    else               timer_q <= timer_q - 1'b1;
                end
                default: state_q <= ST_IDLE;
            endcase
            // Preload overrides a same-cycle step increment.
            if (pos_load_i) pos_q <= pos_value_i;
        end
    end

    assign position_o = pos_q;
    assign step_o     = step_q;
    assign dir_o      = dir_q;
    assign busy_o     = (state_q != ST_IDLE);

endmodule

// File: rtl/multi_axis_step_generator.sv
// rtl/multi_axis_step_generator.sv - NUM_AXES independent STEP/DIR channels on packed buses
module multi_axis_step_generator
    import step_gen_pkg::*;
#(
    parameter int NUM_AXES    = 4,
    parameter int PERIOD_BITS = 32,
    parameter int POS_BITS    = 32,
    parameter int STEP_LEN    = 160,
    parameter int DIR_SETUP   = 40,
    parameter int DIR_HOLD    = 40
) (
    input  logic                          clk_i,
    input  logic                          reset_i,
    input  logic                          enable_i,
    input  logic [NUM_AXES*PERIOD_BITS-1:0] period_i,
    input  logic [NUM_AXES-1:0]           pos_load_i,
    input  logic [NUM_AXES*POS_BITS-1:0]  pos_value_i,
    output logic [NUM_AXES*POS_BITS-1:0]  position_o,
    output logic [NUM_AXES-1:0]           step_o,
    output logic [NUM_AXES-1:0]           dir_o,
    output logic [NUM_AXES-1:0]           busy_o
);

    for (genvar i = 0; i < NUM_AXES; i++) begin : g_axis
        step_axis_channel #(
            .PERIOD_BITS(PERIOD_BITS),
            .POS_BITS   (POS_BITS),
            .STEP_LEN   (STEP_LEN),
            .DIR_SETUP  (DIR_SETUP),
            .DIR_HOLD   (DIR_HOLD)
        ) u_channel (
            .clk_i      (clk_i),
            .reset_i    (reset_i),
            .enable_i   (enable_i),
            .period_i   (period_i[i*PERIOD_BITS +: PERIOD_BITS]),
            .pos_load_i (pos_load_i[i]),
            .pos_value_i(pos_value_i[i*POS_BITS +: POS_BITS]),
            .position_o (position_o[i*POS_BITS +: POS_BITS]),
            .step_o     (step_o[i]),
            .dir_o      (dir_o[i]),
            .busy_o     (busy_o[i])
        );
    end

endmodule
